// File: rtl/seq_divider.sv
// seq_divider: 32-bit restoring divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN to honor sign_i (two's complement operands).
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign_i,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem, r_dvd, r_dvs;
  logic [32:0] w_shift;
  logic        w_ge, w_accept;
  logic [31:0] w_rem_n, w_quo_n, w_a_mag, w_b_mag, w_quo_o, w_rem_o;
  assign w_accept = r_state == IDLE && start;
  assign w_shift  = {r_rem, r_dvd[31]};
  assign w_ge     = w_shift >= {1'b0, r_dvs};
  assign w_rem_n  = w_ge ? 32'(w_shift - {1'b0, r_dvs}) : w_shift[31:0];
  assign w_quo_n  = {r_dvd[30:0], w_ge};
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_neg_q, r_neg_r;
  logic w_sa, w_sb;
  assign w_sa    = sign_i & dividend[31];
  assign w_sb    = sign_i & divisor[31];
  assign w_a_mag = w_sa ? -dividend : dividend;
  assign w_b_mag = w_sb ? -divisor : divisor;
  assign w_quo_o = r_neg_q ? -w_quo_n : w_quo_n;
  assign w_rem_o = r_neg_r ? -w_rem_n : w_rem_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
    end
`else
  logic w_unused;
  assign w_unused = sign_i;
  assign w_a_mag  = dividend;
  assign w_b_mag  = divisor;
  assign w_quo_o  = w_quo_n;
  assign w_rem_o  = w_rem_n;
`endif
  always_comb begin
    w_next = r_state == IDLE ? (start ? (divisor == '0 ? DONE : RUN) : IDLE) :
             r_state == RUN  ? (r_cnt == 6'd31 ? DONE : RUN) : IDLE;
    busy   = r_state == RUN;
    done   = r_state == DONE;
  end
  // results are registered on the edge that enters DONE and held until the next one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rem <= '0;
        r_cnt <= '0;
        r_dvd <= w_a_mag;
        r_dvs <= w_b_mag;
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend;
          div_zero  <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_rem <= w_rem_n;
        r_dvd <= w_quo_n;
        r_cnt <= r_cnt + 6'd1;
        if (r_cnt == 6'd31) begin
          quotient  <= w_quo_o;
          remainder <= w_rem_o;
          div_zero  <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: random and directed stimulus checked every cycle against an arithmetic model.
module tb_seq_divider;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sign_i = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;
  int errors = 0, checks = 0, dones = 0;
  int n, nb, d0;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign_i(sign_i),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 0) return {32'hFFFFFFFF, a, 1'b1};
    if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0, 1'b0};
      return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b)), 1'b0};
    end
    return {a / b, a % b, 1'b0};
  endfunction

  // timing model: cycles left in the run, a one-cycle done, and the result it publishes
  int          m_left = 0;
  logic        m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_q = '0, m_r = '0;
  logic [64:0] m_pend = '0;
  wire         m_busy = m_left != 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dz   <= 1'b0;
      m_pend <= '0;
    end else if (m_done) m_done <= 1'b0;
    else if (m_left > 1) m_left <= m_left - 1;
    else if (m_left == 1) begin
      m_left <= 0;
      m_done <= 1'b1;
      {m_q, m_r, m_dz} <= m_pend;
    end else if (start) begin
      if (divisor == 0) begin
        m_done <= 1'b1;
        {m_q, m_r, m_dz} <= ref_div(dividend, divisor, sign_i & SGN);
      end else begin
        m_left <= 32;
        m_pend <= ref_div(dividend, divisor, sign_i & SGN);
      end
    end

  initial forever begin
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== {m_busy, m_done, m_q, m_r, m_dz}) begin
      errors++;
      $display("FAIL cycle t=%0t dut busy=%b done=%b q=%h r=%h dz=%b model busy=%b done=%b q=%h r=%h dz=%b",
               $time, busy, done, quotient, remainder, div_zero, m_busy, m_done, m_q, m_r, m_dz);
    end
    if (done === 1'b1) dones++;
  end

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s, output int cyc, output int nbusy);
    dividend = a;
    divisor  = b;
    sign_i   = s;
    start    = 1'b1;
    cyc      = 0;
    nbusy    = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (cyc == 1) begin
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
      end
    end while (!done && cyc < 100);
  endtask

  initial begin
    #7;
    chk("reset_state", {busy, done, quotient, remainder, div_zero}, '0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    run(100, 7, 1'b0, n, nb);
    chk("u100_7_latency", n, 33);
    chk("u100_7_busy_cycles", nb, 32);
    chk("u100_7_result", {quotient, remainder, div_zero}, {32'd14, 32'd2, 1'b0});
    @(negedge clk);
    run(1234, 0, 1'b0, n, nb);
    chk("div0_latency", n, 1);
    chk("div0_result", {quotient, remainder, div_zero}, {32'hFFFFFFFF, 32'd1234, 1'b1});
    @(negedge clk);
    d0 = dones;
    dividend = 1000; divisor = 3; sign_i = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    dividend = 5; divisor = 0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (40) @(negedge clk);
    chk("ignore_start_dones", dones - d0, 1);
    chk("ignore_start_result", {quotient, remainder, div_zero}, {32'd333, 32'd1, 1'b0});
    dividend = 999; divisor = 4; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (19) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", {busy, done, quotient, remainder, div_zero}, '0);
    #1 rst_n = 1'b1;
    d0 = dones;
    run(50, 5, 1'b0, n, nb);
    repeat (5) @(negedge clk);
    chk("post_reset_latency", n, 33);
    chk("post_reset_dones", dones - d0, 1);
    chk("post_reset_result", {quotient, remainder, div_zero}, {32'd10, 32'd0, 1'b0});
    @(negedge clk);
    run(32'hFFFFFFF9, 2, 1'b1, n, nb);
`ifdef SEQ_DIVIDER_SIGNED_EN
    chk("s_m7_2_result", {quotient, remainder, div_zero}, {32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    @(negedge clk);
    run(32'h80000000, 32'hFFFFFFFF, 1'b1, n, nb);
    chk("s_min_m1_result", {quotient, remainder, div_zero}, {32'h80000000, 32'h0, 1'b0});
`else
    chk("sign_ignored_result", {quotient, remainder, div_zero}, {32'h7FFFFFFC, 32'h1, 1'b0});
`endif
    repeat (3000) begin
      @(negedge clk);
      start    = $urandom_range(0, 3) == 0;
      sign_i   = 1'($urandom);
      dividend = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       divisor = 0;
        1:       divisor = 1;
        2:       divisor = 32'hFFFFFFFF;
        3, 4:    divisor = $urandom_range(1, 15);
        default: divisor = $urandom;
      endcase
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
